// File: rtl/battle_turn_ctrl.sv
// Purpose : turn sequencer/arbiter for the battle datapath; round-robin attack grant,
//           GARO settle window, roll sampling, hit resolution and saturating HP damage.
// Latency : ack is high for the cycle after E0+5 (E0 = edge registering the request rise);
//           turn period is SETTLE+3 cycles. Requests are never back-pressured: one
//           request per player is held pending, further edges while pending are dropped.
// Ports   : clk, reset (async active-low); p1_req/p2_req attack requests (rising edge);
//           rnd GARO nibble; rng_run GARO enable; p1_ack/p2_ack turn-resolved pulses;
//           hit (valid with ack); roll last sample; p1_hp/p2_hp; winner; busy.
module battle_turn_ctrl #(
    parameter int HP_INIT    = 9,
    parameter int HIT_THRESH = 7,
    parameter int DMG        = 1,
    parameter int SETTLE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic [3:0] rnd,
    output logic       rng_run,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic       hit,
    output logic [3:0] roll,
    output logic [3:0] p1_hp,
    output logic [3:0] p2_hp,
    output logic [1:0] winner,
    output logic       busy
);

    localparam logic [3:0] HP0     = 4'(HP_INIT);
    localparam logic [3:0] THRESH  = 4'(HIT_THRESH);
    localparam logic [3:0] DMG4    = 4'(DMG);
    localparam logic [3:0] CNT_TOP = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_SAMPLE,
        S_APPLY,
        S_OVER
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       p1_req_d;
    logic       p2_req_d;
    logic       p1_pend;
    logic       p2_pend;
    // Holds the player of the current (or most recent) turn; doubles as the
    // round-robin "last granted" pointer. 1 = player 2.
    logic       gnt_p2;

    logic       p1_rise;
    logic       p2_rise;
    logic       p1_clr;
    logic       p2_clr;
    logic       grant_p2_nxt;
    logic       roll_hit;
    logic [3:0] opp_hp;
    logic [3:0] opp_new;

    always_comb begin
        p1_rise      = p1_req & ~p1_req_d;
        p2_rise      = p2_req & ~p2_req_d;
        p1_clr       = (state == S_APPLY) && !gnt_p2;
        p2_clr       = (state == S_APPLY) &&  gnt_p2;
        // Both pending: serve whoever was not granted last; otherwise the one pending.
        grant_p2_nxt = (p1_pend && p2_pend) ? !gnt_p2 : !p1_pend;
        roll_hit     = rnd > THRESH;
        opp_hp       = gnt_p2 ? p1_hp : p2_hp;
        opp_new      = opp_hp;
        if (roll_hit) begin
            opp_new = (opp_hp >= DMG4) ? (opp_hp - DMG4) : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            p1_req_d <= 1'b0;
            p2_req_d <= 1'b0;
            p1_pend  <= 1'b0;
            p2_pend  <= 1'b0;
            gnt_p2   <= 1'b1;
            rng_run  <= 1'b0;
            p1_ack   <= 1'b0;
            p2_ack   <= 1'b0;
            hit      <= 1'b0;
            roll     <= 4'd0;
            p1_hp    <= HP0;
            p2_hp    <= HP0;
            winner   <= 2'b00;
            busy     <= 1'b0;
        end else begin
            p1_req_d <= p1_req;
            p2_req_d <= p2_req;
            p1_ack   <= 1'b0;
            p2_ack   <= 1'b0;
            hit      <= 1'b0;

            // A fresh rise beats the clear of a turn being retired on the same edge.
            if (state == S_OVER) begin
                p1_pend <= 1'b0;
                p2_pend <= 1'b0;
            end else begin
                p1_pend <= p1_rise | (p1_pend & ~p1_clr);
                p2_pend <= p2_rise | (p2_pend & ~p2_clr);
            end

            case (state)
                S_IDLE: begin
                    if ((p1_pend || p2_pend) && (winner == 2'b00)) begin
                        state   <= S_SPIN;
                        gnt_p2  <= grant_p2_nxt;
                        cnt     <= CNT_TOP;
                        rng_run <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_SPIN: begin
                    if (cnt == 4'd0) begin
                        state   <= S_SAMPLE;
                        rng_run <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    roll <= rnd;
                    if (gnt_p2) begin
                        p1_hp <= opp_new;
                    end else begin
                        p2_hp <= opp_new;
                    end
                    if (opp_new == 4'd0) begin
                        winner <= gnt_p2 ? 2'b10 : 2'b01;
                    end
                    p1_ack <= ~gnt_p2;
                    p2_ack <= gnt_p2;
                    hit    <= roll_hit;
                    state  <= S_APPLY;
                end
                S_APPLY: begin
                    busy  <= 1'b0;
                    state <= (winner != 2'b00) ? S_OVER : S_IDLE;
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Purpose : self-checking bench for battle_turn_ctrl with a turn-level reference model.
// Latency : expected acks carry the cycle they must appear in (request cycle + 6/12).
// Ports   : drives a default-parameter DUT and a DMG=4 DUT sharing clock and reset.
module tb_battle_turn_ctrl;

    localparam int HP_INIT = 9;
    localparam int THRESH  = 7;
    localparam int DMG     = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1_req, p2_req;
    logic [3:0] rnd;
    logic       rng_run, p1_ack, p2_ack, hit, busy;
    logic [3:0] roll, p1_hp, p2_hp;
    logic [1:0] winner;

    logic       s_p1_req, s_p2_req;
    logic [3:0] s_rnd;
    logic       s_rng_run, s_p1_ack, s_p2_ack, s_hit, s_busy;
    logic [3:0] s_roll, s_p1_hp, s_p2_hp;
    logic [1:0] s_winner;

    always #5 clk = ~clk;

    battle_turn_ctrl u_dut (
        .clk(clk), .reset(reset), .p1_req(p1_req), .p2_req(p2_req), .rnd(rnd),
        .rng_run(rng_run), .p1_ack(p1_ack), .p2_ack(p2_ack), .hit(hit), .roll(roll),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .winner(winner), .busy(busy)
    );

    battle_turn_ctrl #(.HP_INIT(9), .HIT_THRESH(7), .DMG(4), .SETTLE(3)) u_sat (
        .clk(clk), .reset(reset), .p1_req(s_p1_req), .p2_req(s_p2_req), .rnd(s_rnd),
        .rng_run(s_rng_run), .p1_ack(s_p1_ack), .p2_ack(s_p2_ack), .hit(s_hit), .roll(s_roll),
        .p1_hp(s_p1_hp), .p2_hp(s_p2_hp), .winner(s_winner), .busy(s_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Turn-level reference model: a turn is (player, roll); its effect follows the game rules.
    typedef struct {
        int         player;
        int         hit;
        int         roll;
        int         hp1;
        int         hp2;
        int         win;
        int         at;
    } exp_t;

    exp_t sbq[$];
    int   m_hp1, m_hp2, m_win, m_last;
    bit   over_seen;
    int   run_len;

    function automatic void model_reset();
        sbq.delete();
        m_hp1  = HP_INIT;
        m_hp2  = HP_INIT;
        m_win  = 0;
        m_last = 2;
    endfunction

    function automatic void model_turn(input int player, input int r, input int at);
        exp_t e;
        if (m_win != 0) return;
        e.player = player;
        e.hit    = (r > THRESH) ? 1 : 0;
        if (e.hit == 1) begin
            if (player == 1) m_hp2 = (m_hp2 > DMG) ? m_hp2 - DMG : 0;
            else             m_hp1 = (m_hp1 > DMG) ? m_hp1 - DMG : 0;
        end
        if (m_hp1 == 0 || m_hp2 == 0) m_win = player;
        m_last = player;
        e.roll = r;
        e.hp1  = m_hp1;
        e.hp2  = m_hp2;
        e.win  = m_win;
        e.at   = at;
        sbq.push_back(e);
    endfunction

    // Monitor: pops an expectation whenever an ack appears; also checks spin window length.
    always @(negedge clk) begin
        if (!reset) begin
            run_len   = 0;
            over_seen = 1'b0;
        end else begin
            if (rng_run) begin
                run_len++;
            end else if (run_len != 0) begin
                chk("spin_len", run_len, 3);
                run_len = 0;
            end
            if (p1_ack || p2_ack) begin
                if (p1_ack && p2_ack) chk("dual_ack", 1, 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_player", p2_ack ? 2 : 1, e.player);
                    chk("ack_cycle", cyc, e.at);
                    chk("hit", hit, e.hit);
                    chk("roll", roll, e.roll);
                    chk("p1_hp", p1_hp, e.hp1);
                    chk("p2_hp", p2_hp, e.hp2);
                    chk("winner", winner, e.win);
                    chk("busy_in_apply", busy, 1);
                    if (e.win != 0) over_seen = 1'b1;
                end
            end
        end
    end

    // kind: 0 p1, 1 p2, 2 tie, 3 p1 then p2 later, 4 p2 then p1 later.
    task automatic do_round(input int kind, input logic [3:0] r);
        int k, d, first;
        @(negedge clk);
        rnd = r;
        k   = cyc;
        d   = $urandom_range(4, 1);
        case (kind)
            0: begin p1_req = 1'b1; model_turn(1, r, k + 6); end
            1: begin p2_req = 1'b1; model_turn(2, r, k + 6); end
            2: begin
                p1_req = 1'b1;
                p2_req = 1'b1;
                first  = (m_last == 2) ? 1 : 2;
                model_turn(first, r, k + 6);
                model_turn(3 - first, r, k + 12);
            end
            3: begin p1_req = 1'b1; model_turn(1, r, k + 6); model_turn(2, r, k + 12); end
            default: begin p2_req = 1'b1; model_turn(2, r, k + 6); model_turn(1, r, k + 12); end
        endcase
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == d && kind == 3) p2_req = 1'b1;
            if (i == d && kind == 4) p1_req = 1'b1;
            if (i == 8) begin
                p1_req = 1'b0;
                p2_req = 1'b0;
            end
        end
        if (over_seen) begin
            chk("over_rng_run", rng_run, 0);
            chk("over_busy", busy, 0);
        end
    endtask

    task automatic new_game();
        chk("drained", sbq.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    int sat_exp[3] = '{5, 1, 0};

    initial begin
        int j;
        bit got;
        reset    = 1'b0;
        p1_req   = 1'b0;
        p2_req   = 1'b0;
        rnd      = 4'd0;
        s_p1_req = 1'b0;
        s_p2_req = 1'b0;
        s_rnd    = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rng_run", rng_run, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_p2_ack", p2_ack, 0);
        chk("rst_hit", hit, 0);
        chk("rst_roll", roll, 0);
        chk("rst_p1_hp", p1_hp, HP_INIT);
        chk("rst_p2_hp", p2_hp, HP_INIT);
        chk("rst_winner", winner, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // Directed: single hit, threshold boundary, repeated ties.
        do_round(0, 4'hC);
        do_round(1, 4'h7);
        do_round(1, 4'h8);
        do_round(2, 4'h3);
        do_round(2, 4'h9);
        // Random play until (likely) a knockout.
        for (int n = 0; n < 60; n++) do_round($urandom_range(4, 0), 4'($urandom_range(15, 0)));

        // Directed knockout by player 1, then requests must be ignored.
        new_game();
        for (int n = 0; n < 9; n++) do_round(0, 4'hF);
        chk("ko_winner", winner, 1);
        chk("ko_p2_hp", p2_hp, 0);
        do_round(2, 4'hF);
        do_round(1, 4'hF);
        do_round(0, 4'hF);

        // Reset asserted mid-SPIN with p1_req held through deassertion.
        new_game();
        @(negedge clk);
        rnd    = 4'hC;
        p1_req = 1'b1;
        model_turn(1, 4'hC, cyc + 6);
        repeat (3) @(negedge clk);
        chk("spin_rng_run_hi", rng_run, 1);
        chk("spin_busy_hi", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rng_run", rng_run, 0);
        chk("mid_busy", busy, 0);
        chk("mid_acks", {p1_ack, p2_ack}, 0);
        chk("mid_p1_hp", p1_hp, HP_INIT);
        chk("mid_p2_hp", p2_hp, HP_INIT);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        j = cyc;
        model_turn(1, 4'hC, j + 6);
        repeat (4) @(negedge clk);
        p1_req = 1'b0;
        repeat (14) @(negedge clk);

        // Random play, second game.
        new_game();
        for (int n = 0; n < 60; n++) do_round($urandom_range(4, 0), 4'($urandom_range(15, 0)));

        // Saturating damage on the DMG=4 instance.
        new_game();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_rnd    = 4'hF;
            s_p1_req = 1'b1;
            got      = 1'b0;
            for (int t = 0; t < 15 && !got; t++) begin
                @(negedge clk);
                if (s_p1_ack) begin
                    got = 1'b1;
                    chk("sat_p2_hp", s_p2_hp, sat_exp[i]);
                    chk("sat_p1_hp", s_p1_hp, 9);
                    chk("sat_winner", s_winner, (i == 2) ? 1 : 0);
                end
            end
            if (!got) chk("sat_ack_timeout", 0, 1);
            s_p1_req = 1'b0;
            repeat (3) @(negedge clk);
        end

        chk("final_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
